// File: rtl/serial_vector_loader.sv
// Bit-serial frame receiver: shifts WIDTH bits MSB first, checks optional even parity,
// and presents the assembled vector on a valid/ready handshake held until accepted.
module serial_vector_loader #(
  parameter int WIDTH  = 3,
  parameter bit PARITY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sin_start,
  input  logic             i_sin_valid,
  input  logic             i_sin_bit,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_parity_err,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_count;
  logic             r_acc;
  logic             r_out_valid;
  logic             r_parity_err;
  logic             r_busy;
  logic             w_last_bit;
  logic             w_parity_ok;
  logic             w_clear;
  logic             w_shift;
  logic             w_load;
  logic             w_perr;

  // A one-bit frame has no older bits to keep; the new bit is the whole vector.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign w_shifted = i_sin_bit;
    end else begin : g_shift_wn
      assign w_shifted = {r_shreg[WIDTH-2:0], i_sin_bit};
    end
  endgenerate

  assign w_last_bit  = (r_count == CW'(WIDTH - 1));
  assign w_parity_ok = (i_sin_bit == r_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_sin_start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_sin_start) w_state_next = S_SHIFT;
        else if (i_sin_valid && w_last_bit) w_state_next = PARITY ? S_PAR : S_HOLD;
      end
      S_PAR: begin
        if (i_sin_start) w_state_next = S_SHIFT;
        else if (i_sin_valid) w_state_next = w_parity_ok ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (r_out_valid && i_out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Start strobes are only honoured outside HOLD, where they also override sin_valid.
  always_comb begin
    w_clear = i_sin_start && (r_state != S_HOLD);
    w_shift = (r_state == S_SHIFT) && i_sin_valid && !i_sin_start;
    w_load  = (w_shift && w_last_bit && !PARITY) ||
              ((r_state == S_PAR) && i_sin_valid && !i_sin_start && w_parity_ok);
    w_perr  = PARITY && (r_state == S_PAR) && i_sin_valid && !i_sin_start && !w_parity_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg      <= '0;
      r_count      <= '0;
      r_acc        <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_clear) begin
        r_shreg <= '0;
        r_count <= '0;
        r_acc   <= 1'b0;
      end else if (w_shift) begin
        r_shreg <= w_shifted;
        r_count <= r_count + 1'b1;
        r_acc   <= r_acc ^ i_sin_bit;
      end
      if (w_load) begin
        r_out_data <= (r_state == S_PAR) ? r_shreg : w_shifted;
      end
      r_out_valid  <= (w_state_next == S_HOLD);
      r_parity_err <= w_perr;
      r_busy       <= (w_state_next == S_SHIFT) || (w_state_next == S_PAR);
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_parity_err = r_parity_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_serial_vector_loader.sv
// Self-checking bench: table of 3-bit parity frames with a scoreboard monitor, plus
// hand-written HOLD, restart, async-reset and 4-bit no-parity sequences.
module tb_serial_vector_loader;

  logic       clk;
  logic       rst;
  logic       sin_start, sin_valid, sin_bit, out_ready;
  logic       out_valid, parity_err, busy;
  logic [2:0] out_data;
  logic       s4_start, s4_valid, s4_bit, out4_ready;
  logic       out4_valid, perr4, busy4;
  logic [3:0] out4_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [2:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [2:0] data;
    logic       par;
    logic       exp_err;
    logic [2:0] exp_data;
  } vec_t;

  serial_vector_loader #(.WIDTH(3), .PARITY(1'b1)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_sin_start (sin_start),
    .i_sin_valid (sin_valid),
    .i_sin_bit   (sin_bit),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_parity_err(parity_err),
    .o_busy      (busy)
  );

  serial_vector_loader #(.WIDTH(4), .PARITY(1'b0)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .i_sin_start (s4_start),
    .i_sin_valid (s4_valid),
    .i_sin_bit   (s4_bit),
    .i_out_ready (out4_ready),
    .o_out_valid (out4_valid),
    .o_out_data  (out4_data),
    .o_parity_err(perr4),
    .o_busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start strobe with a simultaneous valid bit that the DUT must ignore.
  task automatic do_start();
    sin_start = 1'b1;
    sin_valid = 1'b1;
    sin_bit   = 1'b1;
    tick();
    sin_start = 1'b0;
    sin_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sin_valid = 1'b1;
    sin_bit   = b;
    tick();
    sin_valid = 1'b0;
  endtask

  // Scoreboard monitor: each delivered vector or parity error consumes one expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_valid", out_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_valid_kind", out_valid, !e.is_err);
          check("sb_data", out_data, e.data);
        end
      end
      if (parity_err) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_perr", parity_err, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_perr_kind", parity_err, e.is_err);
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [3:0] pat;
    vecs[0] = '{3'b001, 1'b1, 1'b0, 3'b001};
    vecs[1] = '{3'b101, 1'b1, 1'b1, 3'b001};
    vecs[2] = '{3'b011, 1'b0, 1'b0, 3'b011};
    vecs[3] = '{3'b111, 1'b1, 1'b0, 3'b111};
    vecs[4] = '{3'b010, 1'b0, 1'b1, 3'b111};
    vecs[5] = '{3'b100, 1'b1, 1'b0, 3'b100};
    vecs[6] = '{3'b000, 1'b0, 1'b0, 3'b000};
    vecs[7] = '{3'b110, 1'b1, 1'b1, 3'b000};

    rst = 1'b1;
    sin_start = 0; sin_valid = 0; sin_bit = 0; out_ready = 1;
    s4_start = 0; s4_valid = 0; s4_bit = 0; out4_ready = 1;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_perr", parity_err, 0);
    check("rst_busy", busy, 0);
    check("rst4_valid", out4_valid, 0);
    check("rst4_data", out4_data, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_start();
      check("busy_after_start", busy, 1);
      for (int b = 2; b >= 0; b--) send_bit(vecs[i].data[b]);
      check("busy_before_par", busy, 1);
      sb_q.push_back('{vecs[i].exp_err, vecs[i].exp_data});
      send_bit(vecs[i].par);
      check("vec_valid", out_valid, !vecs[i].exp_err);
      check("vec_perr", parity_err, vecs[i].exp_err);
      check("vec_data", out_data, vecs[i].exp_data);
      check("vec_busy_done", busy, 0);
      tick();
      check("vec_valid_clr", out_valid, 0);
      check("vec_perr_clr", parity_err, 0);
    end

    // HOLD with downstream stalled; a new frame arriving meanwhile is dropped.
    out_ready = 1'b0;
    do_start();
    send_bit(1); send_bit(1); send_bit(0);
    sb_q.push_back('{1'b0, 3'b110});
    send_bit(0);
    for (int i = 0; i < 5; i++) begin
      sin_start = (i == 0);
      sin_valid = (i >= 1 && i <= 3);
      sin_bit   = i[0];
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 3'b110);
      check("hold_busy", busy, 0);
      tick();
    end
    sin_start = 0; sin_valid = 0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_valid_pre_ack", out_valid, 1);
    tick();
    check("hold_valid_ack", out_valid, 0);
    check("hold_dropped_busy", busy, 0);
    tick();
    check("hold_data_kept", out_data, 3'b110);

    // Restart mid-frame discards the partial bits without error.
    do_start();
    send_bit(1); send_bit(0);
    do_start();
    check("restart_busy", busy, 1);
    send_bit(0); send_bit(1); send_bit(1);
    sb_q.push_back('{1'b0, 3'b011});
    send_bit(0);
    check("restart_valid", out_valid, 1);
    check("restart_data", out_data, 3'b011);
    check("restart_perr", parity_err, 0);
    tick();

    // Asynchronous reset between edges after two bits.
    do_start();
    send_bit(1); send_bit(0);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_perr", parity_err, 0);
    #3 rst = 1'b0;
    tick();
    do_start();
    send_bit(1); send_bit(1); send_bit(1);
    sb_q.push_back('{1'b0, 3'b111});
    send_bit(1);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 3'b111);
    tick();

    // WIDTH=4, no parity, three idle cycles between bits.
    pat = 4'b1001;
    s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    check("w4_busy_start", busy4, 1);
    for (int i = 0; i < 4; i++) begin
      s4_valid = 1'b1;
      s4_bit   = pat[3-i];
      tick();
      s4_valid = 1'b0;
      if (i < 3) begin
        check("w4_valid_early", out4_valid, 0);
        repeat (3) tick();
        check("w4_busy_gap", busy4, 1);
      end else begin
        check("w4_valid_rise", out4_valid, 1);
        check("w4_data", out4_data, 4'b1001);
        check("w4_busy_done", busy4, 0);
        check("w4_perr", perr4, 0);
      end
    end
    tick();
    check("w4_valid_clr", out4_valid, 0);
    check("w4_data_kept", out4_data, 4'b1001);

    repeat (2) tick();
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_vector_loader.md
# serial_vector_loader

Bit-serial front end for the 3-input combinational function under test. It collects a framed serial bit stream MSB first and checks an even-parity bit. It then presents the result as a parallel input vector on a valid/ready handshake. Its `out_data` drives `{A,B,C}` of the function stage directly, and the vector is held stable until the downstream side accepts it.

## Interface
- `WIDTH`, 3: data bits per frame; `out_data` width. Legal range 1..16.
- `PARITY`, 1: 1 = one even-parity bit follows the data bits; 0 = no parity bit, `parity_err` never asserts.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sin_start`  in  1  frame-start strobe, one cycle.
- `sin_valid`  in  1  `sin_bit` is valid this cycle.
- `sin_bit`  in  1  serial data, MSB first, then the parity bit.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_valid`  out  1  `out_data` holds a new, parity-clean vector.
- `out_data`  out  WIDTH  assembled vector; bit WIDTH-1 = first received bit (A).
- `parity_err`  out  1  one-cycle pulse when a frame fails parity.
- `busy`  out  1  a frame is in progress (state SHIFT or PAR).

## Operation
- States:
  - IDLE: waiting for a frame.
  - SHIFT: receiving data bits.
  - PAR: receiving the parity bit.
  - HOLD: `out_valid` high, waiting for handshake.
- IDLE -> SHIFT on `sin_start`:
  - clears the shift register and bit counter.
  - `sin_valid` in the same cycle as `sin_start` is ignored; data starts on the next `sin_valid`.
- SHIFT, on each `sin_valid`:
  - shreg <= {shreg[WIDTH-2:0], sin_bit}; count++.
  - Running parity acc ^= `sin_bit`.
- SHIFT exits on the WIDTH-th bit:
  - -> PAR if PARITY=1.
  - else the vector is loaded into `out_data` and the state goes to HOLD.
- PAR, on `sin_valid`:
  - if `sin_bit` == acc: load `out_data`, go to HOLD.
  - else pulse `parity_err`, discard the frame, go to IDLE.
- HOLD:
  - `out_valid`=1; `out_data` stable.
  - `sin_valid` and `sin_start` are ignored; the frame is dropped, not queued.
  - On `out_valid` && `out_ready` -> IDLE.
- `sin_start` during SHIFT or PAR restarts the frame: count, acc and shreg are cleared and the state goes to SHIFT. The partial frame is discarded with no error.
- `out_data` keeps its last delivered value after the handshake and after parity errors. It changes only on a successful frame.
- Cycles with `sin_valid`=0 are stalls of any length; no timeout.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `parity_err`=0, `busy`=0, count=0, acc=0.
- Reset mid-frame or in HOLD aborts immediately and asynchronously, with all outputs at their reset values.
- `out_valid` rises on the edge that samples the final bit: the parity bit, or the last data bit when PARITY=0. `out_data` updates on that same edge.
- `out_valid` falls on the edge where `out_valid` && `out_ready` is sampled.
- `out_ready` held high allows a minimum one-cycle HOLD.
- `parity_err` is high for exactly the cycle after the edge that sampled the bad parity bit.
- `busy` is high from the cycle after `sin_start` until the edge that samples the final bit.
- Minimum frame-to-frame period with back-to-back `sin_valid` and `out_ready`=1 is WIDTH+PARITY+2 cycles (start + bits + HOLD).
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset, then a frame with `sin_start` followed by bits 0,0,1 and parity 1, with `out_ready`=1:
  - `out_valid` pulses one cycle with `out_data`=3'b001.
  - Downstream F=0 after settling.
- Frame 1,0,1 with parity 1, where the parity is wrong because the correct parity is 0:
  - `parity_err` pulses once.
  - `out_valid` stays 0; `out_data` keeps its previous value 3'b001.
- Frame 1,1,0 with parity 0 and `out_ready`=0 for 5 cycles:
  - `out_valid`=1 and `out_data`=3'b110 are held for all 5 cycles.
  - A new `sin_start` with bits arriving during HOLD is ignored.
  - `out_ready`=1 then clears `out_valid` on the next edge.
- Bits 1,0, then `sin_start`, then 0,1,1 with parity 0: `out_data`=3'b011 and no `parity_err`.
- `rst` asserted asynchronously mid-frame, between clock edges, after 2 bits:
  - outputs are zero immediately; `busy`=0.
  - A following clean frame 1,1,1 with parity 1 gives `out_data`=3'b111.
- PARITY=0, WIDTH=4, frame 1,0,0,1 with gaps of 3 idle cycles between bits: `out_data`=4'b1001, `out_valid` rises on the edge that samples the 4th bit.
